// File: rtl/vc_buffer_pkg.sv
// Shared width helpers and constants for the virtual-channel buffer.
package vc_buffer_pkg;

    // Width of every per-channel statistics counter.
    localparam int STAT_W = 16;

    // Channel-select width; a single channel still needs one select bit.
    function automatic int calc_vcw(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    // Occupancy width; must be able to hold the value DEPTH itself.
    function automatic int calc_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width for indices 0..DEPTH-1.
    function automatic int calc_pw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vc_fifo_ctrl.sv
// Per-channel FIFO bookkeeping: head/tail pointers, occupancy, status flags
// and (when VC_BUFFER_STATS_EN is defined) drop and peak statistics.
module vc_fifo_ctrl
    import vc_buffer_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    localparam int CW       = calc_cw(DEPTH),
    localparam int PW       = calc_pw(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              rd_req,
    output logic              wr_ok,
    output logic              rd_ok,
    output logic [PW-1:0]     head,
    output logic [PW-1:0]     tail,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [STAT_W-1:0] drop_cnt,
    output logic [CW-1:0]     peak_cnt
);

    logic [CW-1:0] count_nxt;

    // Flags come only from the registered count, so a same-cycle write never
    // makes an empty channel readable and a same-cycle read never frees a slot.
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CW'(AF_THRESH));
    assign wr_ok       = wr_req && !full;
    assign rd_ok       = rd_req && !empty;

    // Next occupancy: a simultaneous read and write cancel out.
    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    // Pointer and occupancy registers; pointers wrap at DEPTH-1 for any DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                tail <= (tail == PW'(DEPTH - 1)) ? '0 : tail + 1'b1;
            end
            if (rd_ok) begin
                head <= (head == PW'(DEPTH - 1)) ? '0 : head + 1'b1;
            end
            count <= count_nxt;
        end
    end

`ifdef VC_BUFFER_STATS_EN
    // Saturating rejected-write counter and high-water mark of occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            peak_cnt <= '0;
        end else begin
            if (wr_req && full && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (count_nxt > peak_cnt) begin
                peak_cnt <= count_nxt;
            end
        end
    end
`else
    assign drop_cnt = '0;
    assign peak_cnt = '0;
`endif

endmodule

// File: rtl/vc_buffer.sv
// Multi-channel FIFO buffer: NUM_VC independent FIFOs sharing one storage
// array addressed vc*DEPTH+ptr, one write port and one registered read port.
// Define VC_BUFFER_STATS_EN to build the per-channel drop/peak statistics.
module vc_buffer
    import vc_buffer_pkg::*;
#(
    parameter int NUM_VC    = 4,
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 64,
    parameter int AF_THRESH = 6,
    localparam int VCW      = calc_vcw(NUM_VC),
    localparam int CW       = calc_cw(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [VCW-1:0]           in_vc,
    input  logic                     produce,
    input  logic [VCW-1:0]           rd_vc,
    input  logic                     consume,
    output logic [WIDTH-1:0]         out_data,
    output logic [VCW-1:0]           out_vc,
    output logic                     out_valid,
    output logic [NUM_VC-1:0]        full,
    output logic [NUM_VC-1:0]        empty,
    output logic [NUM_VC-1:0]        almost_full,
    output logic [NUM_VC*CW-1:0]     count,
    output logic                     drop,
    output logic [NUM_VC*STAT_W-1:0] drop_cnt,
    output logic [NUM_VC*CW-1:0]     peak_cnt
);

    localparam int PW = calc_pw(DEPTH);
    localparam int AW = calc_pw(NUM_VC * DEPTH);

    logic [WIDTH-1:0]  mem [NUM_VC*DEPTH];
    logic [NUM_VC-1:0] wr_hit;
    logic [NUM_VC-1:0] rd_hit;
    logic [NUM_VC-1:0] wr_ok;
    logic [NUM_VC-1:0] rd_ok;
    logic [PW-1:0]     head [NUM_VC];
    logic [PW-1:0]     tail [NUM_VC];
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     raddr;

    // A channel id with no matching controller hits nothing, so it behaves
    // as permanently full for writes and permanently empty for reads.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign wr_hit[v] = (in_vc == VCW'(v));
        assign rd_hit[v] = (rd_vc == VCW'(v));

        vc_fifo_ctrl #(
            .DEPTH     (DEPTH),
            .AF_THRESH (AF_THRESH)
        ) u_ctrl (
            .clk         (clk),
            .rst         (rst),
            .wr_req      (produce && !rst && wr_hit[v]),
            .rd_req      (consume && !rst && rd_hit[v]),
            .wr_ok       (wr_ok[v]),
            .rd_ok       (rd_ok[v]),
            .head        (head[v]),
            .tail        (tail[v]),
            .count       (count[v*CW +: CW]),
            .full        (full[v]),
            .empty       (empty[v]),
            .almost_full (almost_full[v]),
            .drop_cnt    (drop_cnt[v*STAT_W +: STAT_W]),
            .peak_cnt    (peak_cnt[v*CW +: CW])
        );
    end

    // Flatten the selected channel's tail/head into storage addresses.
    always_comb begin
        waddr = '0;
        raddr = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_hit[v]) begin
                waddr = AW'(v * DEPTH) + AW'(tail[v]);
            end
            if (rd_hit[v]) begin
                raddr = AW'(v * DEPTH) + AW'(head[v]);
            end
        end
    end

    // Shared storage; never reset, only accepted writes land here.
    always_ff @(posedge clk) begin
        if (|wr_ok) begin
            mem[waddr] <= in_data;
        end
    end

    // Registered read port and drop pulse; data/vc hold when no read occurs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_vc    <= '0;
            drop      <= 1'b0;
        end else begin
            out_valid <= |rd_ok;
            drop      <= produce && !(|wr_ok);
            if (|rd_ok) begin
                out_data <= mem[raddr];
                out_vc   <= rd_vc;
            end
        end
    end

endmodule

// File: tb/tb_vc_buffer.sv
// Bench for vc_buffer: two instances (DEPTH=8 and DEPTH=5) share one
// directed stimulus stream and are checked every cycle against a queue model.
module tb_vc_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_data = '0;
    logic [1:0]  in_vc = '0;
    logic        produce = 1'b0;
    logic [1:0]  rd_vc = '0;
    logic        consume = 1'b0;

    logic [63:0] out_data_a, out_data_b;
    logic [1:0]  out_vc_a, out_vc_b;
    logic        out_valid_a, out_valid_b;
    logic [3:0]  full_a, full_b, empty_a, empty_b, af_a, af_b;
    logic [15:0] count_a, peak_a;
    logic [11:0] count_b, peak_b;
    logic        drop_a, drop_b;
    logic [63:0] dcnt_a, dcnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vc_buffer #(.NUM_VC(4), .DEPTH(8), .WIDTH(64), .AF_THRESH(6)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_vc(in_vc), .produce(produce),
        .rd_vc(rd_vc), .consume(consume), .out_data(out_data_a), .out_vc(out_vc_a),
        .out_valid(out_valid_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
        .count(count_a), .drop(drop_a), .drop_cnt(dcnt_a), .peak_cnt(peak_a)
    );

    vc_buffer #(.NUM_VC(4), .DEPTH(5), .WIDTH(64), .AF_THRESH(4)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_vc(in_vc), .produce(produce),
        .rd_vc(rd_vc), .consume(consume), .out_data(out_data_b), .out_vc(out_vc_b),
        .out_valid(out_valid_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
        .count(count_b), .drop(drop_b), .drop_cnt(dcnt_b), .peak_cnt(peak_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // ---------------- behavioural model: one queue per (instance, channel)
    logic [63:0] mq [8][$];
    bit          model_live = 0;
    bit          exp_valid [2];
    logic [63:0] exp_data [2];
    logic [1:0]  exp_vc [2];
    bit          exp_drop [2];
    int          exp_dcnt [2][4];
    int          exp_peak [2][4];

    function automatic int dep_of(input int d);
        return (d == 0) ? 8 : 5;
    endfunction

    function automatic int af_of(input int d);
        return (d == 0) ? 6 : 4;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int v = 0; v < 4; v++) begin
                    mq[d*4+v].delete();
                    exp_dcnt[d][v] = 0;
                    exp_peak[d][v] = 0;
                end
                exp_valid[d] = 0;
                exp_data[d]  = '0;
                exp_vc[d]    = '0;
                exp_drop[d]  = 0;
                model_live   = 1;
            end else begin
                bit rok, wok;
                rok = consume && (mq[d*4+int'(rd_vc)].size() != 0);
                wok = produce && (mq[d*4+int'(in_vc)].size() < dep_of(d));
                if (rok) begin
                    exp_data[d]  = mq[d*4+int'(rd_vc)].pop_front();
                    exp_vc[d]    = rd_vc;
                    exp_valid[d] = 1;
                end else begin
                    exp_valid[d] = 0;
                end
                exp_drop[d] = produce && !wok;
                if (produce && !wok && exp_dcnt[d][int'(in_vc)] < 65535)
                    exp_dcnt[d][int'(in_vc)]++;
                if (wok) mq[d*4+int'(in_vc)].push_back(in_data);
                for (int v = 0; v < 4; v++)
                    if (mq[d*4+v].size() > exp_peak[d][v]) exp_peak[d][v] = mq[d*4+v].size();
            end
        end
    end

    // ---------------- per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_live) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("out_valid d%0d", d), 64'(d == 0 ? out_valid_a : out_valid_b), 64'(exp_valid[d]));
                chk($sformatf("out_data d%0d", d), (d == 0 ? out_data_a : out_data_b), exp_data[d]);
                chk($sformatf("out_vc d%0d", d), 64'(d == 0 ? out_vc_a : out_vc_b), 64'(exp_vc[d]));
                chk($sformatf("drop d%0d", d), 64'(d == 0 ? drop_a : drop_b), 64'(exp_drop[d]));
                for (int v = 0; v < 4; v++) begin
                    int sz, act_cnt, act_pk, act_dc;
                    sz      = mq[d*4+v].size();
                    act_cnt = (d == 0) ? int'(count_a[v*4 +: 4]) : int'(count_b[v*3 +: 3]);
                    act_pk  = (d == 0) ? int'(peak_a[v*4 +: 4]) : int'(peak_b[v*3 +: 3]);
                    act_dc  = (d == 0) ? int'(dcnt_a[v*16 +: 16]) : int'(dcnt_b[v*16 +: 16]);
                    chk($sformatf("count d%0d v%0d", d, v), 64'(act_cnt), 64'(sz));
                    chk($sformatf("full d%0d v%0d", d, v),
                        64'(d == 0 ? full_a[v] : full_b[v]), 64'(sz == dep_of(d)));
                    chk($sformatf("empty d%0d v%0d", d, v),
                        64'(d == 0 ? empty_a[v] : empty_b[v]), 64'(sz == 0));
                    chk($sformatf("almost_full d%0d v%0d", d, v),
                        64'(d == 0 ? af_a[v] : af_b[v]), 64'(sz >= af_of(d)));
`ifdef VC_BUFFER_STATS_EN
                    chk($sformatf("drop_cnt d%0d v%0d", d, v), 64'(act_dc), 64'(exp_dcnt[d][v]));
                    chk($sformatf("peak_cnt d%0d v%0d", d, v), 64'(act_pk), 64'(exp_peak[d][v]));
`else
                    chk($sformatf("drop_cnt d%0d v%0d", d, v), 64'(act_dc), 64'(0));
                    chk($sformatf("peak_cnt d%0d v%0d", d, v), 64'(act_pk), 64'(0));
`endif
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at a falling edge)
    task automatic cyc(input logic p, input logic [1:0] iv, input logic [63:0] dat,
                       input logic c, input logic [1:0] rv);
        produce = p;
        in_vc   = iv;
        in_data = dat;
        consume = c;
        rd_vc   = rv;
        @(negedge clk);
        produce = 1'b0;
        consume = 1'b0;
    endtask

    task automatic wr(input logic [1:0] iv, input logic [63:0] dat);
        cyc(1'b1, iv, dat, 1'b0, 2'd0);
    endtask

    task automatic rd(input logic [1:0] rv);
        cyc(1'b0, 2'd0, 64'd0, 1'b1, rv);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset();
        chk("reset empty", 64'(empty_a), 64'hF);
        chk("reset full", 64'(full_a), 64'h0);
        chk("reset count", 64'(count_a), 64'h0);
        chk("reset out_valid", 64'(out_valid_a), 64'h0);
        chk("reset out_data", out_data_a, 64'h0);

        // basic write/read on vc0
        wr(2'd0, 64'hA1);
        wr(2'd0, 64'hA2);
        rd(2'd0);
        chk("vc0 first read data", out_data_a, 64'hA1);
        chk("vc0 first read valid", 64'(out_valid_a), 64'h1);
        chk("vc0 first read vc", 64'(out_vc_a), 64'h0);
        rd(2'd0);
        chk("vc0 second read data", out_data_a, 64'hA2);
        chk("vc0 second read valid", 64'(out_valid_a), 64'h1);

        // fill vc2, overflow by one
        for (int i = 0; i < 8; i++) begin
            wr(2'd2, 64'h20 + 64'(i));
            if (i == 4) chk("vc2 af at 5", 64'(af_a[2]), 64'h0);
            if (i == 5) chk("vc2 af at 6", 64'(af_a[2]), 64'h1);
        end
        chk("vc2 full", 64'(full_a[2]), 64'h1);
        chk("vc2 count 8", 64'(count_a[8 +: 4]), 64'h8);
        wr(2'd2, 64'hFF);
        chk("vc2 drop pulse", 64'(drop_a), 64'h1);
`ifdef VC_BUFFER_STATS_EN
        chk("vc2 drop_cnt", 64'(dcnt_a[32 +: 16]), 64'h1);
`endif
        for (int i = 0; i < 8; i++) rd(2'd2);
        chk("vc2 last drained", out_data_a, 64'h27);

        // interleaved channels
        for (int i = 0; i < 4; i++) begin
            wr(2'd1, 64'h10 + 64'(i));
            wr(2'd3, 64'h30 + 64'(i));
        end
        for (int i = 0; i < 4; i++) begin
            rd(2'd3);
            chk("vc3 order", out_data_a, 64'h30 + 64'(i));
        end
        for (int i = 0; i < 4; i++) begin
            rd(2'd1);
            chk("vc1 order", out_data_a, 64'h10 + 64'(i));
        end

        // simultaneous produce/consume on full then empty vc0
        for (int i = 0; i < 8; i++) wr(2'd0, 64'h40 + 64'(i));
        cyc(1'b1, 2'd0, 64'hEE, 1'b1, 2'd0);
        chk("full rw drop", 64'(drop_a), 64'h1);
        chk("full rw valid", 64'(out_valid_a), 64'h1);
        chk("full rw data", out_data_a, 64'h40);
        chk("full rw count", 64'(count_a[0 +: 4]), 64'h7);
        for (int i = 0; i < 7; i++) rd(2'd0);
        cyc(1'b1, 2'd0, 64'h55, 1'b1, 2'd0);
        chk("empty rw valid", 64'(out_valid_a), 64'h0);
        chk("empty rw count", 64'(count_a[0 +: 4]), 64'h1);
        rd(2'd0);
        chk("empty rw data", out_data_a, 64'h55);

        // pointer wrap on the DEPTH=5 instance
        do_reset();
        for (int i = 0; i < 20; i++) begin
            wr(2'd1, 64'h100 + 64'(i));
            rd(2'd1);
            chk("wrap data d5", out_data_b, 64'h100 + 64'(i));
        end
`ifdef VC_BUFFER_STATS_EN
        chk("wrap peak d5", 64'(peak_b[3 +: 3]), 64'h1);
`endif

        // reset in the middle of traffic
        for (int i = 0; i < 3; i++) wr(2'd0, 64'h60 + 64'(i));
        rst = 1'b1;
        rd(2'd0);
        rst = 1'b0;
        chk("mid-reset out_valid", 64'(out_valid_a), 64'h0);
        chk("mid-reset count", 64'(count_a), 64'h0);
        chk("mid-reset empty", 64'(empty_a), 64'hF);
        chk("mid-reset drop_cnt", dcnt_a, 64'h0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
